sy_rtc_gen: RTL and testbench
=============================

# sy_rtc_gen

Real-time-clock reference generator that sits directly upstream of the core-local interruptor (CLINT) and drives its `rtc_i` input. A phase accumulator running on the system clock produces a square wave at a nominal RTC frequency, 32.768 kHz by default, plus a one-cycle tick on each rising edge. The CLINT's edge synchronizer turns each rising edge into one `mtime` increment. The increment is runtime-programmable through a shadowed, glitch-free update so that software or boot logic can trim the frequency without producing runt pulses.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: system clock frequency.
- `RTC_FREQ_HZ`, default 32_768: target `rtc_o` frequency.
- `ACC_WIDTH`, default 32: accumulator width W, legal range 8..32.
- `DEF_INC`, derived localparam:
  - value is floor(2·RTC_FREQ_HZ·2^W / CLK_FREQ_HZ), computed in 64-bit arithmetic, then clamped to [1, 2^(W-1)];
  - 5_629_499 at the defaults.
- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  reset; synchronous, active-low.
- `en_i`  in  1  run enable; low freezes generation.
- `cfg_we_i`  in  1  single-cycle write strobe for a new increment.
- `cfg_inc_i`  in  W  requested increment.
- `cfg_inc_o`  out  W  increment currently in use (`inc_q`).
- `cfg_busy_o`  out  1  a written increment is pending and not yet applied.
- `rtc_o`  out  1  generated RTC square wave, registered; connects to CLINT `rtc_i`.
- `tick_o`  out  1  one-cycle pulse, registered, high in the same cycle `rtc_o` first goes high.

## Operation
- State registers:
  - `acc_q[W-1:0]`: accumulator;
  - `inc_q[W-1:0]`: active increment;
  - `pend_q[W-1:0]` with `pend_v_q`: shadowed pending increment and its valid flag;
  - `rtc_q`: square-wave output;
  - `tick_q`: tick output.
- Reset (`rst_i` low at a `clk_i` edge): `acc_q`=0, `inc_q`=DEF_INC, `pend_v_q`=0, `rtc_o`=0, `tick_o`=0, `cfg_busy_o`=0, `cfg_inc_o`=DEF_INC. Reset has priority over every other input.
- Accumulate (en_i=1):
  - sum = {1'b0,acc_q} + {1'b0,inc_q}, W+1 bits wide;
  - carry = sum[W];
  - `acc_q` <= sum[W-1:0], so wrap-around is modulo 2^W and no residue is lost;
  - on carry, `rtc_q` <= ~`rtc_q`.
- Tick: `tick_q` <= carry & ~`rtc_q` & en_i, so it pulses only on a 0→1 transition; otherwise it is 0.
- Clamp on write: the written value is clamp(`cfg_inc_i`):
  - 0 becomes 1;
  - values above 2^(W-1) become 2^(W-1);
  - this guarantees at least 2 clk cycles between toggles, so every `rtc_o` level lasts ≥2 cycles and the downstream two-stage synchronizer cannot miss an edge.
- Write: on `cfg_we_i`, `pend_q` <= clamp(`cfg_inc_i`) and `pend_v_q` <= 1. A write while a value is already pending overwrites it; last write wins.
- Apply (pending increment becomes active):
  - when en_i=1: on a carry cycle with `pend_v_q`=1, `inc_q` <= `pend_q` and `pend_v_q` <= 0. The new increment takes effect from the next cycle, so each half-period is built entirely from one increment.
  - when en_i=0: `pend_q` is applied on the next edge regardless of carry.
- Simultaneous write and apply in the same cycle: the old `pend_q` is applied, and the newly written value becomes pending with `pend_v_q` staying 1.
- Disable (en_i=0):
  - `acc_q` and `rtc_q` hold;
  - `tick_q`=0;
  - re-enabling resumes from the held phase, with no extra or lost edge.
- Reset mid-period discards phase and any pending write.

## Timing
- The `rtc_o` and `tick_o` change on the same edge, after the carry cycle.
- Latency: carry computed in cycle n → `rtc_o`/`tick_o` visible after edge n.
- `cfg_busy_o` rises the edge after `cfg_we_i`.
  - With en_i=1, it falls on the edge that applies the value, at most one half-period later.
  - With en_i=0, it falls one edge after it rose.
- Period of `rtc_o` = 2·2^W/inc clk cycles on average; the jitter on any single edge is at most 1 clk.
- Static check (simulation-only assertion block): CLK_FREQ_HZ ≥ 4·RTC_FREQ_HZ and 8 ≤ W ≤ 32; otherwise $fatal.

## Test plan
- W=8, reset, write inc=128 with en_i=0, then en_i=1:
  - `rtc_o` rises after the 2nd enabled edge, then toggles every 2 cycles (period 4);
  - `tick_o` pulses once every 4 cycles;
  - `cfg_inc_o`=128.
- W=8, write inc=0 → `cfg_inc_o`=1; write inc=255 → `cfg_inc_o`=128 (clamp).
- W=8, running at inc=64, write 128 mid-half-period:
  - `cfg_busy_o`=1 until the next toggle;
  - the toggle spacing changes from 4 to 2 cycles only after that toggle;
  - no level shorter than 2 cycles appears.
- W=8, inc=64:
  - drop en_i for 10 cycles mid-period → `rtc_o` and phase hold, `tick_o`=0;
  - after re-enable, the remaining cycles to the next toggle equal those before the pause.
- Defaults (50 MHz, W=32): `cfg_inc_o`=5_629_499 after reset; over 1_000_000 clk cycles, the count of `tick_o` pulses is 655 or 656.
- Assert `rst_i`=0 for one cycle mid-run with a write pending → all outputs return to reset values and `cfg_busy_o`=0 on the next edge.

Source files
------------

// File: rtl/sy_rtc_gen_if.sv
// Configuration and output bundle of the RTC reference generator.
// The generator itself uses the slave modport; whoever drives enable and
// programs the increment uses the master modport.
interface sy_rtc_gen_if #(
    parameter int ACC_WIDTH = 32
);
    logic                 en_i;
    logic                 cfg_we_i;
    logic [ACC_WIDTH-1:0] cfg_inc_i;
    logic [ACC_WIDTH-1:0] cfg_inc_o;
    logic                 cfg_busy_o;
    logic                 rtc_o;
    logic                 tick_o;

    modport master (
        output en_i,
        output cfg_we_i,
        output cfg_inc_i,
        input  cfg_inc_o,
        input  cfg_busy_o,
        input  rtc_o,
        input  tick_o
    );

    modport slave (
        input  en_i,
        input  cfg_we_i,
        input  cfg_inc_i,
        output cfg_inc_o,
        output cfg_busy_o,
        output rtc_o,
        output tick_o
    );
endinterface

// File: rtl/sy_rtc_gen.sv
// Real-time-clock reference generator feeding the CLINT rtc input.
// A phase accumulator adds the active increment every enabled cycle. Each
// carry out of the accumulator toggles the square wave, and a one-cycle tick
// marks every rising edge. A new increment is shadowed and only swapped in on
// a carry, so each half-period is built from one increment and no runt level
// can reach the downstream synchronizer.
module sy_rtc_gen #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned RTC_FREQ_HZ = 32_768,
    parameter int          ACC_WIDTH   = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    sy_rtc_gen_if.slave   bus
);

    // Half of the accumulator range; an increment this large toggles the
    // output at most every second cycle, which is the fastest the CLINT
    // synchronizer can follow.
    localparam logic [63:0] HALF_64 = 64'd1 << (ACC_WIDTH - 1);

    // Nominal increment for the requested frequency, rounded down.
    localparam logic [63:0] RAW_INC_64 =
        (64'd2 * 64'(RTC_FREQ_HZ) * (64'd1 << ACC_WIDTH)) / 64'(CLK_FREQ_HZ);

    localparam logic [63:0] DEF_INC_64 =
        (RAW_INC_64 == 64'd0)    ? 64'd1   :
        (RAW_INC_64 > HALF_64)   ? HALF_64 :
                                   RAW_INC_64;

    localparam logic [ACC_WIDTH-1:0] DEF_INC = DEF_INC_64[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] HALF_W  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] ONE_W   = {{(ACC_WIDTH-1){1'b0}}, 1'b1};

    // Reject parameter sets that cannot produce a clean RTC edge stream.
    if ((CLK_FREQ_HZ < 4 * RTC_FREQ_HZ) || (ACC_WIDTH < 8) || (ACC_WIDTH > 32)) begin : g_param_check
        $fatal(1, "sy_rtc_gen: illegal CLK_FREQ_HZ/RTC_FREQ_HZ/ACC_WIDTH combination");
    end

    // A zero increment would stall the clock and anything above half range
    // could toggle on consecutive cycles, so written values are forced into
    // the legal window.
    function automatic logic [ACC_WIDTH-1:0] clamp_inc(input logic [ACC_WIDTH-1:0] v);
        if (v == '0) begin
            return ONE_W;
        end
        if (v > HALF_W) begin
            return HALF_W;
        end
        return v;
    endfunction

    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] inc_q;
    logic [ACC_WIDTH-1:0] pend_q;
    logic                 pend_v_q;
    logic                 rtc_q;
    logic                 tick_q;

    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic                 apply;
    logic                 rise;

    // Next phase, carry out, and the decision to swap in a pending increment.
    // While disabled nothing is generated, so a pending value can be taken
    // immediately without splitting a half-period.
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, inc_q};
        carry = sum[ACC_WIDTH];
        apply = pend_v_q & (~bus.en_i | carry);
        rise  = bus.en_i & carry & ~rtc_q;
    end

    // Phase accumulator, square wave and rising-edge tick; disabling freezes
    // the phase so re-enabling neither adds nor drops an edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            acc_q  <= '0;
            rtc_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            if (bus.en_i) begin
                acc_q <= sum[ACC_WIDTH-1:0];
                if (carry) begin
                    rtc_q <= ~rtc_q;
                end
            end
            tick_q <= rise;
        end
    end

    // Active and shadow increments; a write in the same cycle as an apply
    // lands in the shadow after the older pending value has been consumed.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            inc_q    <= DEF_INC;
            pend_q   <= DEF_INC;
            pend_v_q <= 1'b0;
        end else begin
            if (apply) begin
                inc_q <= pend_q;
            end
            if (bus.cfg_we_i) begin
                pend_q   <= clamp_inc(bus.cfg_inc_i);
                pend_v_q <= 1'b1;
            end else if (apply) begin
                pend_v_q <= 1'b0;
            end
        end
    end

    assign bus.cfg_inc_o  = inc_q;
    assign bus.cfg_busy_o = pend_v_q;
    assign bus.rtc_o      = rtc_q;
    assign bus.tick_o     = tick_q;

endmodule

// File: tb/tb_sy_rtc_gen.sv
// Self-checking bench for sy_rtc_gen: an 8-bit instance exercised with
// directed and random stimulus against a behavioural model, plus a default
// 32-bit instance whose tick count over a fixed window is checked.
module tb_sy_rtc_gen;

    localparam int          N32   = 20000;
    localparam int unsigned DEF32 = 5_629_499;
    // 2*32768*256/50e6 rounds down to 0, which clamps to 1.
    localparam int          DEF8  = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       we;
    logic [7:0] incIn;
    logic       en32;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int cnt8   = 0;
    int cnt32  = 0;
    int runLen = 2;
    int minRun = 1000;
    logic prevRtc = 1'b0;

    // Behavioural model state for the 8-bit instance.
    int m_acc = 0;
    int m_inc = DEF8;
    int m_pend = DEF8;
    int m_pv = 0;
    int m_rtc = 0;
    int m_tick = 0;

    // Free-running system clock.
    always #5 clk = ~clk;

    sy_rtc_gen_if #(.ACC_WIDTH(8))  b8();
    sy_rtc_gen_if #(.ACC_WIDTH(32)) b32();

    assign b8.en_i      = en;
    assign b8.cfg_we_i  = we;
    assign b8.cfg_inc_i = incIn;

    assign b32.en_i      = en32;
    assign b32.cfg_we_i  = 1'b0;
    assign b32.cfg_inc_i = '0;

    sy_rtc_gen #(.ACC_WIDTH(8)) dut8 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b8.slave)
    );

    sy_rtc_gen dut32 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b32.slave)
    );

    function automatic int clampInc(input int v);
        if (v == 0) return 1;
        if (v > 128) return 128;
        return v;
    endfunction

    task automatic applyStimulus(input logic r, input logic e, input logic w, input logic [7:0] v);
        rst   = r;
        en    = e;
        we    = w;
        incIn = v;
    endtask

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cycle, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic modelStep();
        int s;
        int carry;
        int doApply;
        if (!rst) begin
            m_acc = 0; m_inc = DEF8; m_pv = 0; m_rtc = 0; m_tick = 0;
        end else begin
            s       = m_acc + m_inc;
            carry   = (en && s >= 256) ? 1 : 0;
            doApply = (m_pv != 0 && (!en || carry != 0)) ? 1 : 0;
            m_tick  = (carry != 0 && m_rtc == 0) ? 1 : 0;
            if (en) m_acc = s % 256;
            if (carry != 0) m_rtc = 1 - m_rtc;
            if (doApply != 0) begin
                m_inc = m_pend;
                m_pv  = 0;
            end
            if (we) begin
                m_pend = clampInc(int'(incIn));
                m_pv   = 1;
            end
        end
    endtask

    task automatic checkOutput();
        checkVal("rtc8",  b8.rtc_o,      m_rtc);
        checkVal("tick8", b8.tick_o,     m_tick);
        checkVal("inc8",  b8.cfg_inc_o,  m_inc);
        checkVal("busy8", b8.cfg_busy_o, m_pv);
    endtask

    task automatic trackLevel();
        if (!rst) begin
            runLen  = 2;
            prevRtc = 1'b0;
        end else if (b8.rtc_o === prevRtc) begin
            runLen++;
        end else begin
            if (runLen < minRun) minRun = runLen;
            runLen  = 1;
            prevRtc = b8.rtc_o;
        end
    endtask

    task automatic stepCycle();
        modelStep();
        @(posedge clk);
        #1;
        cycle++;
        if (b8.tick_o === 1'b1)  cnt8++;
        if (b32.tick_o === 1'b1) cnt32++;
        trackLevel();
        checkOutput();
    endtask

    // Step until the 8-bit square wave changes level, with a cycle budget.
    task automatic waitToggle(output int n);
        logic start;
        start = b8.rtc_o;
        n = 0;
        do begin
            stepCycle();
            n++;
        end while (b8.rtc_o === start && n < 32);
        checks++;
        assert (b8.rtc_o !== start) else begin
            errors++;
            $error("[TB] FAIL toggle_timeout cycle=%0d observed=%0d expected=toggle", cycle, n);
        end
    endtask

    // Directed scenarios followed by a random run, then the summary.
    initial begin
        int n;
        logic held;
        longint unsigned carries32;

        en32 = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        stepCycle();
        stepCycle();
        checkVal("rst_rtc8",   b8.rtc_o,      0);
        checkVal("rst_tick8",  b8.tick_o,     0);
        checkVal("rst_busy8",  b8.cfg_busy_o, 0);
        checkVal("rst_inc8",   b8.cfg_inc_o,  DEF8);
        checkVal("rst_inc32",  b32.cfg_inc_o, DEF32);
        checkVal("rst_busy32", b32.cfg_busy_o, 0);
        checkVal("rst_rtc32",  b32.rtc_o,     0);

        // Default-width instance free-running for a fixed window.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        en32  = 1'b1;
        cnt32 = 0;
        repeat (N32) stepCycle();
        en32 = 1'b0;
        carries32 = (64'(N32) * 64'(DEF32)) >> 32;
        checkVal("ticks32", cnt32, (carries32 + 1) / 2);
        checkVal("rtc32_end", b32.rtc_o, carries32 % 2);
        checkVal("ticks32_near_nominal", (cnt32 >= 12 && cnt32 <= 14), 1);

        // Increment 128 written while disabled, then enabled.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd128);
        stepCycle();
        checkVal("busy_after_write", b8.cfg_busy_o, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        stepCycle();
        checkVal("busy_apply_disabled", b8.cfg_busy_o, 0);
        checkVal("inc_128", b8.cfg_inc_o, 128);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        stepCycle();
        checkVal("rtc_after_en1", b8.rtc_o, 0);
        stepCycle();
        checkVal("rtc_after_en2", b8.rtc_o, 1);
        checkVal("tick_after_en2", b8.tick_o, 1);
        cnt8 = 0;
        repeat (8) stepCycle();
        checkVal("ticks_per_8_cycles", cnt8, 2);

        // Clamp of out-of-range writes.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        stepCycle();
        checkVal("clamp_zero", b8.cfg_inc_o, 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd255);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        stepCycle();
        checkVal("clamp_255", b8.cfg_inc_o, 128);

        // Running at 64, switch to 128 in the middle of a half-period.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd64);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        waitToggle(n);
        waitToggle(n);
        checkVal("spacing_64", n, 4);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd128);
        stepCycle();
        checkVal("busy_mid_half", b8.cfg_busy_o, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        waitToggle(n);
        checkVal("steps_to_apply", n, 2);
        checkVal("busy_after_apply", b8.cfg_busy_o, 0);
        checkVal("inc_after_apply", b8.cfg_inc_o, 128);
        waitToggle(n);
        checkVal("spacing_128", n, 2);

        // Pause mid-period at 64 and resume.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd64);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        waitToggle(n);
        checkVal("spacing_64_again", n, 4);
        stepCycle();
        stepCycle();
        held = b8.rtc_o;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        cnt8 = 0;
        repeat (10) stepCycle();
        checkVal("pause_rtc_hold", b8.rtc_o, held);
        checkVal("pause_no_tick", cnt8, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        waitToggle(n);
        checkVal("resume_remaining", n, 2);

        // Reset while a write is pending.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd77);
        stepCycle();
        checkVal("busy_before_reset", b8.cfg_busy_o, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        stepCycle();
        checkVal("reset_busy", b8.cfg_busy_o, 0);
        checkVal("reset_inc",  b8.cfg_inc_o,  DEF8);
        checkVal("reset_rtc",  b8.rtc_o,      0);
        checkVal("reset_tick", b8.tick_o,     0);

        // Random run against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) != 0,
                          $urandom_range(0, 9) != 0,
                          $urandom_range(0, 7) == 0,
                          8'($urandom_range(0, 255)));
            stepCycle();
        end
        checkVal("min_level_ge_2", (minRun >= 2), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
